ref_luma_ring_buf: RTL and testbench

Parametrised circular reference-luma row buffer for the fetch stage. It holds up to DEPTH rows of PIX_NUM pixels each, written in order by the fetch engine and read by motion estimation with window-relative addresses. A shift command retires the oldest rows as the search window slides, so only new rows are refetched. It also reports fill level, full status and out-of-range reads.

---
 rtl/ref_luma_ring_buf.sv | 154 +++++++++++++++
 tb/tb_ref_luma_ring_buf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_luma_ring_buf.sv
// Circular reference-luma row buffer: in-order row writes, window-relative reads, head retire via shift.
// Optional macro RING_OREG_EN adds a second output register stage (read latency 2 instead of 1).
module ref_luma_ring_buf #(
    parameter int PIX_NUM = 96,
    parameter int PIX_W   = 8,
    parameter int DEPTH   = 96,
    parameter int ADDR_W  = 7
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     wrif_en_i,
    input  logic [PIX_NUM*PIX_W-1:0] wrif_data_i,
    output logic                     wrif_full_o,
    input  logic                     shift_i,
    input  logic [ADDR_W-1:0]        shift_num_i,
    input  logic                     rdif_en_i,
    input  logic [ADDR_W-1:0]        rdif_addr_i,
    output logic                     rdif_rdy_o,
    output logic                     rdif_vld_o,
    output logic [PIX_NUM*PIX_W-1:0] rdif_pdata_o,
    output logic                     rdif_oob_o,
    output logic [ADDR_W:0]          count_o
);

    localparam int                ROW_W    = PIX_NUM * PIX_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    logic [ROW_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] base_ptr_q, base_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_oob_q, rd_oob_d;
    logic [ROW_W-1:0]  rd_data_q, rd_data_d;

    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_oob;
    logic [ADDR_W:0]   rd_sum;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W:0]   amt;
    logic [ADDR_W:0]   base_sum;

    always_comb begin
        full   = (count_q == DEPTH_C);
        // Flush also suppresses the storage write so a flushed row never lands in memory.
        wr_acc = wrif_en_i & ~full & ~flush_i;
        // Storage is single-ported: any write request, accepted or not, blocks the read.
        rd_acc = rdif_en_i & ~wrif_en_i;

        rd_sum = {1'b0, base_ptr_q} + {1'b0, rdif_addr_i};
        if (rd_sum >= DEPTH_C) begin
            rd_row = ADDR_W'(rd_sum - DEPTH_C);
        end else begin
            rd_row = rd_sum[ADDR_W-1:0];
        end
        rd_oob = ({1'b0, rdif_addr_i} >= count_q);

        amt = '0;
        if (shift_i) begin
            amt = ({1'b0, shift_num_i} > count_q) ? count_q : {1'b0, shift_num_i};
        end
        base_sum = {1'b0, base_ptr_q} + amt;

        wr_ptr_d   = wr_ptr_q;
        base_ptr_d = base_ptr_q;
        count_d    = count_q + (ADDR_W + 1)'(wr_acc) - amt;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_ROW) ? '0 : wr_ptr_q + 1'b1;
        end
        if (base_sum >= DEPTH_C) begin
            base_ptr_d = ADDR_W'(base_sum - DEPTH_C);
        end else begin
            base_ptr_d = base_sum[ADDR_W-1:0];
        end

        if (flush_i) begin
            wr_ptr_d   = '0;
            base_ptr_d = '0;
            count_d    = '0;
        end

        rd_vld_d  = rd_acc;
        rd_oob_d  = rd_acc ? rd_oob : rd_oob_q;
        rd_data_d = rd_acc ? mem[rd_row] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wrif_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            base_ptr_q <= '0;
            count_q    <= '0;
            rd_vld_q   <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            base_ptr_q <= base_ptr_d;
            count_q    <= count_d;
            rd_vld_q   <= rd_vld_d;
            rd_oob_q   <= rd_oob_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef RING_OREG_EN
    logic             out_vld_q, out_vld_d;
    logic             out_oob_q, out_oob_d;
    logic [ROW_W-1:0] out_data_q, out_data_d;

    // First stage already holds its data between reads, so a plain copy keeps the hold behaviour.
    always_comb begin
        out_vld_d  = rd_vld_q;
        out_oob_d  = rd_oob_q;
        out_data_d = rd_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q  <= 1'b0;
            out_oob_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_oob_q  <= out_oob_d;
            out_data_q <= out_data_d;
        end
    end

    assign rdif_vld_o   = out_vld_q;
    assign rdif_oob_o   = out_oob_q;
    assign rdif_pdata_o = out_data_q;
`else
    assign rdif_vld_o   = rd_vld_q;
    assign rdif_oob_o   = rd_oob_q;
    assign rdif_pdata_o = rd_data_q;
`endif

    assign rdif_rdy_o  = rd_acc;
    assign wrif_full_o = full;
    assign count_o     = count_q;

endmodule

// File: tb/tb_ref_luma_ring_buf.sv
// Directed bench for ref_luma_ring_buf: fill/readback, drop on full, wrap, clamp, flush and reset.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif
module tb_ref_luma_ring_buf;

    localparam int PIX_NUM = 96;
    localparam int PIX_W   = `PIXEL_WIDTH;
    localparam int DEPTH   = 96;
    localparam int ADDR_W  = 7;
    localparam int ROW_W   = PIX_NUM * PIX_W;
`ifdef RING_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rstn;
    logic              flush_i;
    logic              wrif_en_i;
    logic [ROW_W-1:0]  wrif_data_i;
    logic              wrif_full_o;
    logic              shift_i;
    logic [ADDR_W-1:0] shift_num_i;
    logic              rdif_en_i;
    logic [ADDR_W-1:0] rdif_addr_i;
    logic              rdif_rdy_o;
    logic              rdif_vld_o;
    logic [ROW_W-1:0]  rdif_pdata_o;
    logic              rdif_oob_o;
    logic [ADDR_W:0]   count_o;

    ref_luma_ring_buf #(
        .PIX_NUM(PIX_NUM), .PIX_W(`PIXEL_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .wrif_en_i(wrif_en_i), .wrif_data_i(wrif_data_i), .wrif_full_o(wrif_full_o),
        .shift_i(shift_i), .shift_num_i(shift_num_i),
        .rdif_en_i(rdif_en_i), .rdif_addr_i(rdif_addr_i), .rdif_rdy_o(rdif_rdy_o),
        .rdif_vld_o(rdif_vld_o), .rdif_pdata_o(rdif_pdata_o), .rdif_oob_o(rdif_oob_o),
        .count_o(count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ROW_W-1:0] exp_q[$];
    logic             exp_oob_q[$];
    logic             rd_exp_acc;
    logic [1:0]       acc_hist;

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_val(input logic [7:0] v);
        logic [ROW_W-1:0] r;
        for (int p = 0; p < PIX_NUM; p++) r[p*PIX_W +: PIX_W] = PIX_W'(v);
        return r;
    endfunction

    // expected-acceptance history, used to check read latency
    always @(posedge clk or negedge rstn) begin
        if (!rstn) acc_hist <= 2'b00;
        else       acc_hist <= {acc_hist[0], rd_exp_acc};
    end

    // scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            check("vld_timing", rdif_vld_o, acc_hist[LAT-1]);
            if (rdif_vld_o && exp_q.size() > 0) begin
                check("rd_data", rdif_pdata_o, exp_q.pop_front());
                check("rd_oob", rdif_oob_o, exp_oob_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [7:0] v);
        wrif_en_i   = 1'b1;
        wrif_data_i = row_val(v);
        cyc();
        wrif_en_i   = 1'b0;
    endtask

    task automatic read_row(input int addr, input logic [7:0] v, input logic oob);
        rdif_en_i   = 1'b1;
        rdif_addr_i = ADDR_W'(addr);
        rd_exp_acc  = 1'b1;
        exp_q.push_back(row_val(v));
        exp_oob_q.push_back(oob);
        #1;
        check("rdy", rdif_rdy_o, 1'b1);
        cyc();
        rdif_en_i   = 1'b0;
        rd_exp_acc  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) cyc();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic shift_rows(input int n, input int exp_cnt);
        shift_i     = 1'b1;
        shift_num_i = ADDR_W'(n);
        cyc();
        shift_i     = 1'b0;
        check("count_shift", count_o, exp_cnt);
    endtask

    initial begin
        rstn = 1'b1; flush_i = 0; wrif_en_i = 0; wrif_data_i = '0;
        shift_i = 0; shift_num_i = '0; rdif_en_i = 0; rdif_addr_i = '0; rd_exp_acc = 0;
        #1 rstn = 1'b0;
        #1;
        check("rst_count", count_o, 0);
        check("rst_full", wrif_full_o, 0);
        check("rst_vld", rdif_vld_o, 0);
        check("rst_oob", rdif_oob_o, 0);
        check("rst_pdata", rdif_pdata_o, '0);
        #20 rstn = 1'b1;
        cyc();

        // fill all rows with their index
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                check("count_95", count_o, 95);
                check("full_95", wrif_full_o, 0);
            end
            write_row(8'(i));
        end
        check("count_96", count_o, 96);
        check("full_96", wrif_full_o, 1);

        // back-to-back readback
        for (int i = 0; i < DEPTH; i++) begin
            rdif_en_i   = 1'b1;
            rdif_addr_i = ADDR_W'(i);
            rd_exp_acc  = 1'b1;
            exp_q.push_back(row_val(8'(i)));
            exp_oob_q.push_back(1'b0);
            #1 check("rdy_b2b", rdif_rdy_o, 1'b1);
            cyc();
        end
        rdif_en_i = 1'b0; rd_exp_acc = 1'b0;
        drain();

        // write while full is dropped
        write_row(8'hAA);
        check("count_drop", count_o, 96);
        read_row(0, 8'd0, 1'b0);
        drain();

        // retire 16, refill 16 with wrap
        shift_rows(16, 80);
        for (int i = 96; i < 112; i++) write_row(8'(i));
        check("count_refill", count_o, 96);
        read_row(79, 8'd95, 1'b0);
        read_row(80, 8'd96, 1'b0);
        read_row(95, 8'd111, 1'b0);
        drain();

        // read refused while write requested
        wrif_en_i = 1'b1; wrif_data_i = row_val(8'h77);
        rdif_en_i = 1'b1; rdif_addr_i = '0;
        #1 check("rdy_blocked", rdif_rdy_o, 1'b0);
        cyc();
        wrif_en_i = 1'b0;
        check("count_blocked", count_o, 96);
        read_row(0, 8'd16, 1'b0);
        drain();

        // flush with a read in flight
        flush_i = 1'b1;
        read_row(5, 8'd21, 1'b0);
        flush_i = 1'b0;
        check("count_flush", count_o, 0);
        check("full_flush", wrif_full_o, 0);
        read_row(0, 8'd96, 1'b1);
        drain();

        // shift amount clamped to count
        for (int i = 200; i < 210; i++) write_row(8'(i));
        check("count_10", count_o, 10);
        shift_rows(20, 0);
        read_row(0, 8'd106, 1'b1);
        drain();

        // concurrent write + shift, then read with shift uses pre-shift base
        for (int i = 50; i < 55; i++) write_row(8'(i));
        check("count_5", count_o, 5);
        wrif_en_i = 1'b1; wrif_data_i = row_val(8'd55);
        shift_i = 1'b1; shift_num_i = 7'd3;
        rdif_en_i = 1'b1; rdif_addr_i = '0;
        #1 check("rdy_wr_shift", rdif_rdy_o, 1'b0);
        cyc();
        wrif_en_i = 1'b0;
        check("count_wr_shift", count_o, 3);
        shift_num_i = 7'd1;
        read_row(0, 8'd53, 1'b0);
        shift_i = 1'b0;
        check("count_rd_shift", count_o, 2);
        read_row(1, 8'd55, 1'b0);
        read_row(2, 8'd16, 1'b1);
        drain();

        // async reset while a result is valid
        read_row(0, 8'd54, 1'b0);
        if (LAT == 2) cyc();
        check("vld_pre_rst", rdif_vld_o, 1'b1);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        exp_oob_q.delete();
        check("rst2_vld", rdif_vld_o, 0);
        check("rst2_oob", rdif_oob_o, 0);
        check("rst2_pdata", rdif_pdata_o, '0);
        check("rst2_count", count_o, 0);
        check("rst2_full", wrif_full_o, 0);
        #10 rstn = 1'b1;
        cyc();
        check("count_post_rst", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
